// File: rtl/pedal_pkg.sv
// Shared pedal types: controller states, footswitch codes, gain range and the
// effect/bypass target record with its toggle-or-select resolution rule.
package pedal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        SWITCH,
        WAIT_ACK,
        FADE_IN
    } state_t;

    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;

    typedef struct packed {
        logic [1:0] eff_sel;
        logic       bypass;
    } target_t;

    function automatic int gain_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int GAIN_W_DEF = 8;
    localparam int GAIN_MAX   = gain_max(GAIN_W_DEF);

    // Pressing the active effect's switch toggles bypass; any other switch selects it wet.
    function automatic target_t resolve_target(input logic [2:0] code,
                                               input logic [1:0] cur_eff,
                                               input logic       cur_byp);
        target_t    t;
        logic [2:0] idx;
        idx       = code - P1;
        t.eff_sel = idx[1:0];
        t.bypass  = (idx[1:0] != cur_eff) ? 1'b0 : ~cur_byp;
        return t;
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// Saturating gain ramp: moves STEP per qualified tick, clamped to [0, GAIN_MAX].
// One-cycle update latency; holds its value whenever en or tick is low.
module gain_ramp
    import pedal_pkg::*;
#(
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              dir,
    input  logic              en,
    output logic [GAIN_W-1:0] gain,
    output logic              at_min,
    output logic              at_max
);

    localparam logic [GAIN_W-1:0] GMAX   = GAIN_W'(gain_max(GAIN_W));
    localparam logic [GAIN_W:0]   STEP_X = (GAIN_W+1)'(STEP);

    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W:0]   up_x;

    always_comb begin
        up_x   = {1'b0, gain_q} + STEP_X;
        gain_d = gain_q;
        if (en && tick) begin
            if (dir) begin
                gain_d = (up_x > {1'b0, GMAX}) ? GMAX : up_x[GAIN_W-1:0];
            end else begin
                gain_d = ({1'b0, gain_q} < STEP_X) ? '0 : gain_q - STEP_X[GAIN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gain_q <= GMAX;
        end else begin
            gain_q <= gain_d;
        end
    end

    assign gain   = gain_q;
    assign at_min = (gain_q == '0);
    assign at_max = (gain_q == GMAX);

endmodule

// File: rtl/fx_select_ctrl.sv
// Click-free effect change: fade out, switch effect/bypass, await ack, fade in.
// Requests arriving mid-sequence park in a one-deep, newest-wins pending slot.
module fx_select_ctrl
    import pedal_pkg::*;
#(
    parameter int GAIN_W      = GAIN_W_DEF,
    parameter int STEP        = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        btn_code,
    input  logic              btn_stb,
    input  logic              sample_tick,
    input  logic              sel_ack,
    output logic [1:0]        eff_sel,
    output logic              bypass,
    output logic              eff_sel_stb,
    output logic [GAIN_W-1:0] gain,
    output logic              busy,
    output logic [3:0]        led,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state_q, state_d;
    target_t            tgt_q, tgt_d;
    logic               pend_vld_q, pend_vld_d;
    logic [2:0]         pend_code_q, pend_code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         eff_sel_q, eff_sel_d;
    logic               bypass_q, bypass_d;
    logic               stb_q, stb_d;
    logic               terr_q, terr_d;
    logic               req_vld, ramp_en, ramp_dir, at_min, at_max, fade_in_done;

    assign req_vld      = btn_stb && (btn_code >= P1) && (btn_code <= P4);
    assign ramp_en      = (state_q == FADE_OUT) || (state_q == FADE_IN);
    assign ramp_dir     = (state_q == FADE_IN);
    assign fade_in_done = (state_q == FADE_IN) && at_max;

    gain_ramp #(
        .GAIN_W (GAIN_W),
        .STEP   (STEP)
    ) u_ramp (
        .clk    (clk),
        .reset  (reset),
        .tick   (sample_tick),
        .dir    (ramp_dir),
        .en     (ramp_en),
        .gain   (gain),
        .at_min (at_min),
        .at_max (at_max)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        cnt_d       = cnt_q;
        eff_sel_d   = eff_sel_q;
        bypass_d    = bypass_q;
        stb_d       = 1'b0;
        terr_d      = terr_q;

        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    tgt_d   = resolve_target(btn_code, eff_sel_q, bypass_q);
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (at_min) state_d = SWITCH;
            end
            SWITCH: begin
                eff_sel_d = tgt_q.eff_sel;
                bypass_d  = tgt_q.bypass;
                stb_d     = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack coincident with the strobe predates the new selection.
                if (sel_ack && !stb_q) begin
                    state_d = FADE_IN;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
                    terr_d   = 1'b1;
                    bypass_d = 1'b1;
                    state_d  = FADE_IN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FADE_IN: begin
                if (at_max) begin
                    if (req_vld) begin
                        tgt_d      = resolve_target(btn_code, eff_sel_q, bypass_q);
                        pend_vld_d = 1'b0;
                        state_d    = FADE_OUT;
                    end else if (pend_vld_q) begin
                        tgt_d      = resolve_target(pend_code_q, eff_sel_q, bypass_q);
                        pend_vld_d = 1'b0;
                        state_d    = FADE_OUT;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_vld && (state_q != IDLE) && !fade_in_done) begin
            pend_vld_d  = 1'b1;
            pend_code_d = btn_code;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
            cnt_q       <= '0;
            eff_sel_q   <= '0;
            bypass_q    <= 1'b1;
            stb_q       <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            cnt_q       <= cnt_d;
            eff_sel_q   <= eff_sel_d;
            bypass_q    <= bypass_d;
            stb_q       <= stb_d;
            terr_q      <= terr_d;
        end
    end

    assign eff_sel     = eff_sel_q;
    assign bypass      = bypass_q;
    assign eff_sel_stb = stb_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign led         = bypass_q ? 4'b0000 : (4'b0001 << eff_sel_q);

endmodule

// File: tb/tb_fx_select_ctrl.sv
// Randomized bench for fx_select_ctrl against a press-level model of the
// selected effect, bypass, pending request and timeout flag.
module tb_fx_select_ctrl;

    localparam int GW         = 8;
    localparam int ST         = 4;
    localparam int TO         = 255;
    localparam int FADE_TICKS = (255 + ST - 1) / ST;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    btn_code;
    logic          btn_stb, sample_tick, sel_ack;
    logic [1:0]    eff_sel;
    logic          bypass, eff_sel_stb, busy, timeout_err;
    logic [GW-1:0] gain;
    logic [3:0]    led;

    fx_select_ctrl #(.GAIN_W(GW), .STEP(ST), .ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_code    (btn_code),
        .btn_stb     (btn_stb),
        .sample_tick (sample_tick),
        .sel_ack     (sel_ack),
        .eff_sel     (eff_sel),
        .bypass      (bypass),
        .eff_sel_stb (eff_sel_stb),
        .gain        (gain),
        .busy        (busy),
        .led         (led),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         tick_cnt;
    bit         tick_on;
    logic [1:0] m_eff;
    logic       m_byp, m_terr, m_pend;
    logic [2:0] m_pend_code;
    logic [2:0] m_tgt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] resolve(input logic [2:0] code, input logic [1:0] eff, input logic byp);
        int idx;
        idx = int'(code) - 1;
        if (idx != int'(eff)) return {idx[1:0], 1'b0};
        return {eff, ~byp};
    endfunction

    function automatic logic [3:0] led_of(input logic [1:0] eff, input logic byp);
        logic [3:0] one;
        one = 4'b0001;
        return byp ? 4'b0000 : (one << eff);
    endfunction

    function automatic bit valid_code(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd4);
    endfunction

    task automatic adv();
        sample_tick = tick_on && ($urandom_range(0, 2) != 0);
        if (sample_tick) tick_cnt++;
        @(negedge clk);
        btn_stb     = 1'b0;
        sel_ack     = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic fade_cycle(input bit use_to, input bit extra, input logic [2:0] e1,
                              input logic [2:0] e2, input bit late, input bit rst_mid,
                              output bit more);
        int n;
        int stbs;
        bit aborted;
        more    = 0;
        aborted = 0;
        chk("busy_in_fade", 32'(busy), 1);
        tick_on  = 1;
        tick_cnt = 0;
        for (int i = 0; i < 2000 && gain != '0; i++) begin
            if (extra && (i == 3 || i == 9)) begin
                btn_code = (i == 3) ? e1 : e2;
                btn_stb  = 1'b1;
                if (valid_code(btn_code)) begin
                    m_pend      = 1'b1;
                    m_pend_code = btn_code;
                end
            end
            adv();
        end
        chk("fade_out_ticks", 32'(tick_cnt), FADE_TICKS);
        tick_on = 0;
        adv();
        chk("stb_before", 32'(eff_sel_stb), 0);
        adv();
        chk("stb_pulse", 32'(eff_sel_stb), 1);
        chk("switch_eff", 32'(eff_sel), 32'(m_tgt[2:1]));
        chk("switch_byp", 32'(bypass), 32'(m_tgt[0]));
        chk("switch_led", 32'(led), 32'(led_of(m_tgt[2:1], m_tgt[0])));
        m_eff = m_tgt[2:1];
        m_byp = m_tgt[0];
        adv();
        chk("stb_after", 32'(eff_sel_stb), 0);

        if (use_to) begin
            n    = 0;
            stbs = 0;
            while (!timeout_err && n < 400) begin
                adv();
                n++;
                stbs += int'(eff_sel_stb);
            end
            chk("timeout_cycles_in_window", 32'(n >= 254 && n <= 256), 1);
            chk("timeout_no_stb", 32'(stbs), 0);
            m_byp  = 1'b1;
            m_terr = 1'b1;
            chk("timeout_byp", 32'(bypass), 1);
            chk("timeout_eff", 32'(eff_sel), 32'(m_eff));
            chk("timeout_led", 32'(led), 0);
        end else begin
            repeat ($urandom_range(0, 15)) adv();
            sel_ack = 1'b1;
            adv();
        end

        tick_on  = 1;
        tick_cnt = 0;
        for (int i = 0; i < 2000 && gain != '1 && !aborted; i++) begin
            if (rst_mid && i == 10) begin
                reset = 1'b0;
                #1;
                chk("rst_gain", 32'(gain), 255);
                chk("rst_byp", 32'(bypass), 1);
                chk("rst_eff", 32'(eff_sel), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_led", 32'(led), 0);
                chk("rst_terr", 32'(timeout_err), 0);
                @(negedge clk);
                reset   = 1'b1;
                tick_on = 0;
                m_eff   = 2'd0;
                m_byp   = 1'b1;
                m_terr  = 1'b0;
                m_pend  = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    adv();
                    chk("rst_pending_lost", 32'(busy), 0);
                end
                aborted = 1;
            end else begin
                adv();
            end
        end
        if (!aborted) begin
            chk("fade_in_ticks", 32'(tick_cnt), FADE_TICKS);
            tick_on = 0;
            if (late) begin
                btn_code    = 3'($urandom_range(1, 4));
                btn_stb     = 1'b1;
                m_pend      = 1'b1;
                m_pend_code = btn_code;
            end
            if (m_pend) begin
                m_tgt  = resolve(m_pend_code, m_eff, m_byp);
                m_pend = 1'b0;
                more   = 1;
                adv();
            end else begin
                adv();
                chk("idle_busy", 32'(busy), 0);
                chk("idle_gain", 32'(gain), 255);
                chk("idle_terr", 32'(timeout_err), 32'(m_terr));
            end
        end
    endtask

    task automatic do_press(input logic [2:0] c, input bit use_to, input bit extra,
                            input logic [2:0] e1, input logic [2:0] e2, input bit late,
                            input bit rst_mid);
        bit more;
        btn_code = c;
        btn_stb  = 1'b1;
        adv();
        if (valid_code(c)) begin
            m_tgt = resolve(c, m_eff, m_byp);
            more  = 1;
            for (int k = 0; k < 4 && more; k++) begin
                fade_cycle(use_to && k == 0, extra && k == 0, e1, e2, late && k == 0,
                           rst_mid && k == 0, more);
            end
        end else begin
            chk("ignored_busy", 32'(busy), 0);
            adv();
            chk("ignored_busy_hold", 32'(busy), 0);
            chk("ignored_eff", 32'(eff_sel), 32'(m_eff));
            chk("ignored_byp", 32'(bypass), 32'(m_byp));
        end
    endtask

    initial begin
        int tc;
        reset       = 1'b0;
        btn_code    = 3'd0;
        btn_stb     = 1'b0;
        sample_tick = 1'b0;
        sel_ack     = 1'b0;
        tick_on     = 0;
        tick_cnt    = 0;
        m_eff       = 2'd0;
        m_byp       = 1'b1;
        m_terr      = 1'b0;
        m_pend      = 1'b0;
        m_pend_code = 3'd0;
        m_tgt       = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_eff", 32'(eff_sel), 0);
        chk("reset_byp", 32'(bypass), 1);
        chk("reset_gain", 32'(gain), 255);
        chk("reset_stb", 32'(eff_sel_stb), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_led", 32'(led), 0);
        chk("reset_terr", 32'(timeout_err), 0);
        reset = 1'b1;
        adv();

        do_press(3'd2, 0, 0, 3'd0, 3'd0, 0, 0);
        chk("p2_eff", 32'(eff_sel), 1);
        chk("p2_led", 32'(led), 32'b0010);
        do_press(3'd2, 0, 0, 3'd0, 3'd0, 0, 0);
        chk("p2_again_byp", 32'(bypass), 1);
        chk("p2_again_eff", 32'(eff_sel), 1);
        chk("p2_again_led", 32'(led), 0);
        do_press(3'd2, 0, 0, 3'd0, 3'd0, 0, 0);
        chk("p2_third_byp", 32'(bypass), 0);

        do_press(3'd1, 0, 1, 3'd3, 3'd4, 0, 0);
        chk("newest_pending_eff", 32'(eff_sel), 3);
        chk("newest_pending_led", 32'(led), 32'b1000);

        do_press(3'd0, 0, 0, 3'd0, 3'd0, 0, 0);
        do_press(3'd5, 0, 0, 3'd0, 3'd0, 0, 0);
        do_press(3'd7, 0, 0, 3'd0, 3'd0, 0, 0);

        do_press(3'd2, 0, 0, 3'd0, 3'd0, 1, 0);

        for (int r = 0; r < 24; r++) begin
            do_press(3'($urandom_range(0, 7)), 0, bit'($urandom_range(0, 1)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0), 0);
            chk("rand_eff", 32'(eff_sel), 32'(m_eff));
            chk("rand_byp", 32'(bypass), 32'(m_byp));
        end

        tc = (int'(m_eff) + 1) % 4 + 1;
        do_press(3'(tc), 1, 0, 3'd0, 3'd0, 0, 0);
        chk("terr_set", 32'(timeout_err), 1);
        do_press(3'($urandom_range(1, 4)), 0, 0, 3'd0, 3'd0, 0, 0);
        chk("terr_sticky", 32'(timeout_err), 1);

        do_press(3'd4, 0, 1, 3'd2, 3'd2, 0, 1);
        chk("post_rst_terr", 32'(timeout_err), 0);
        chk("post_rst_byp", 32'(bypass), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
